// File: rtl/uart_rx_hex.sv
// 8N1 UART receiver with mid-bit sampling and ASCII hex-digit decode.
// Received bytes and decoded nibbles are presented with one-cycle strobes.
module uart_rx_hex #(
  parameter int CLKS_PER_BIT = 2084,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_rx_data,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_rx_busy,
  output logic [3:0] o_hex_val,
  output logic       o_hex_valid
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [11:0] BIT_LAST  = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF_LAST = 12'(HALF_BIT - 1);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_s1, rx_s2, rx_hist, fall_q;
  logic        good_d, err_d;
  logic        hex_ok;
  logic [3:0]  hex_nib;

  // Two-flop synchronizer, history flop, and a registered falling-edge pulse.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_hist <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      rx_s1   <= i_rx_data;
      rx_s2   <= rx_s1;
      rx_hist <= rx_s2;
      fall_q  <= rx_hist & ~rx_s2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 12'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    good_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s2;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Returning to IDLE at mid-stop-bit lets a back-to-back start edge be caught.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          good_d  = rx_s2;
          err_d   = ~rx_s2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hex_ok  = 1'b0;
    hex_nib = 4'd0;
    if (shift_q >= 8'h30 && shift_q <= 8'h39) begin
      hex_ok  = 1'b1;
      hex_nib = 4'(shift_q - 8'h30);
    end else if (shift_q >= 8'h61 && shift_q <= 8'h66) begin
      hex_ok  = 1'b1;
      hex_nib = 4'(shift_q - 8'h57);
    end else if (shift_q >= 8'h41 && shift_q <= 8'h46) begin
      hex_ok  = 1'b1;
      hex_nib = 4'(shift_q - 8'h37);
    end
  end

  // Strobes are single-cycle, no back-pressure: a consumer must capture data
  // in the cycle o_rx_valid / o_hex_valid is high; data holds until the next good frame.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rx_data   <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_rx_busy   <= 1'b0;
      o_hex_val   <= '0;
      o_hex_valid <= 1'b0;
    end else begin
      o_rx_valid  <= good_d;
      o_frame_err <= err_d;
      o_hex_valid <= good_d & hex_ok;
      o_rx_busy   <= (state_d != IDLE);
      if (good_d) o_rx_data <= shift_q;
      if (good_d && hex_ok) o_hex_val <= hex_nib;
    end
  end

endmodule

// File: tb/tb_uart_rx_hex.sv
// Bench for uart_rx_hex: three instances (2084, 16, 4 clocks per bit) share
// reset; a monitor pops expected frames (including pulse cycle) from a queue.
module tb_uart_rx_hex;

  typedef struct packed {
    logic [1:0]  inst;
    logic        err;
    logic [7:0]  data;
    logic        hv;
    logic [3:0]  hval;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic [7:0] b;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_hv;
    logic [3:0] exp_hval;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx [3];
  logic [7:0] rx_data [3];
  logic       rx_valid [3];
  logic       frame_err [3];
  logic       rx_busy [3];
  logic [3:0] hex_val [3];
  logic       hex_valid [3];
  logic       prev_pulse [3];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_hex #(.CLKS_PER_BIT(2084)) dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_rx_data(rx[0]), .o_rx_data(rx_data[0]),
    .o_rx_valid(rx_valid[0]), .o_frame_err(frame_err[0]), .o_rx_busy(rx_busy[0]),
    .o_hex_val(hex_val[0]), .o_hex_valid(hex_valid[0]));

  uart_rx_hex #(.CLKS_PER_BIT(16)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_rx_data(rx[1]), .o_rx_data(rx_data[1]),
    .o_rx_valid(rx_valid[1]), .o_frame_err(frame_err[1]), .o_rx_busy(rx_busy[1]),
    .o_hex_val(hex_val[1]), .o_hex_valid(hex_valid[1]));

  uart_rx_hex #(.CLKS_PER_BIT(4)) dut_c (
    .i_clk(clk), .i_rstn(rstn), .i_rx_data(rx[2]), .o_rx_data(rx_data[2]),
    .o_rx_valid(rx_valid[2]), .o_frame_err(frame_err[2]), .o_rx_busy(rx_busy[2]),
    .o_hex_val(hex_val[2]), .o_hex_valid(hex_valid[2]));

  function automatic int cpb_of(input int i);
    return (i == 0) ? 2084 : (i == 1) ? 16 : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Start edge is sampled at cyc+1; state enters START 3 edges later.
  task automatic send_frame(input int i, input logic [7:0] b, input logic stop,
                            input logic push, input logic [7:0] ed,
                            input logic ehv, input logic [3:0] ehval);
    int   c;
    exp_t e;
    c = cpb_of(i);
    if (push) begin
      e.inst = 2'(i);
      e.err  = ~stop;
      e.data = ed;
      e.hv   = ehv;
      e.hval = ehval;
      e.cyc  = 32'(cyc + 4 + c / 2 + 9 * c);
      exp_q.push_back(e);
    end
    rx[i] = 1'b0;
    repeat (c) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx[i] = b[k];
      repeat (c) @(negedge clk);
    end
    rx[i] = stop;
    repeat (c) @(negedge clk);
    rx[i] = 1'b1;
  endtask

  task automatic chk_reset_vals(input int i, input string tag);
    chk({tag, "_rx_data"},   32'(rx_data[i]),   32'h0);
    chk({tag, "_rx_valid"},  32'(rx_valid[i]),  32'h0);
    chk({tag, "_frame_err"}, 32'(frame_err[i]), 32'h0);
    chk({tag, "_rx_busy"},   32'(rx_busy[i]),   32'h0);
    chk({tag, "_hex_val"},   32'(hex_val[i]),   32'h0);
    chk({tag, "_hex_valid"}, 32'(hex_valid[i]), 32'h0);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (prev_pulse[i]) chk("pulse_width", 32'(rx_valid[i] | frame_err[i]), 32'h0);
      if (hex_valid[i]) chk("hex_valid_with_rx_valid", 32'(rx_valid[i]), 32'h1);
      if (rx_valid[i] || frame_err[i]) begin
        chk("pulse_exclusive", 32'(rx_valid[i] & frame_err[i]), 32'h0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_inst", 32'(i), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_inst",  32'(i),            32'(e.inst));
          chk("frame_err",   32'(frame_err[i]), 32'(e.err));
          chk("rx_data",     32'(rx_data[i]),   32'(e.data));
          chk("hex_valid",   32'(hex_valid[i]), 32'(e.hv));
          chk("hex_val",     32'(hex_val[i]),   32'(e.hval));
          chk("pulse_cycle", 32'(cyc),          e.cyc);
        end
      end
      prev_pulse[i] = rx_valid[i] | frame_err[i];
    end
  end

  initial begin
    vec_t vecs [17];
    int   c0;
    int   e_edge;
    int   p_edge;

    vecs[0]  = '{8'h80, 1'b1, 8'h80, 1'b0, 4'd0};
    vecs[1]  = '{8'h30, 1'b1, 8'h30, 1'b1, 4'd0};
    vecs[2]  = '{8'h2F, 1'b1, 8'h2F, 1'b0, 4'd0};
    vecs[3]  = '{8'h39, 1'b1, 8'h39, 1'b1, 4'd9};
    vecs[4]  = '{8'h3A, 1'b1, 8'h3A, 1'b0, 4'd9};
    vecs[5]  = '{8'h41, 1'b1, 8'h41, 1'b1, 4'd10};
    vecs[6]  = '{8'h40, 1'b1, 8'h40, 1'b0, 4'd10};
    vecs[7]  = '{8'h46, 1'b1, 8'h46, 1'b1, 4'd15};
    vecs[8]  = '{8'h47, 1'b1, 8'h47, 1'b0, 4'd15};
    vecs[9]  = '{8'h61, 1'b1, 8'h61, 1'b1, 4'd10};
    vecs[10] = '{8'h60, 1'b1, 8'h60, 1'b0, 4'd10};
    vecs[11] = '{8'h66, 1'b1, 8'h66, 1'b1, 4'd15};
    vecs[12] = '{8'h67, 1'b1, 8'h67, 1'b0, 4'd15};
    vecs[13] = '{8'h00, 1'b1, 8'h00, 1'b0, 4'd15};
    vecs[14] = '{8'hFF, 1'b1, 8'hFF, 1'b0, 4'd15};
    vecs[15] = '{8'h5A, 1'b0, 8'hFF, 1'b0, 4'd15};
    vecs[16] = '{8'h34, 1'b1, 8'h34, 1'b1, 4'd4};

    for (int i = 0; i < 3; i++) begin
      rx[i] = 1'b1;
      prev_pulse[i] = 1'b0;
    end

    // Clock/reset
    rstn = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals(0, "reset_a");
    chk_reset_vals(1, "reset_b");
    chk_reset_vals(2, "reset_c");

    // 0x55 at 2084 clocks per bit, with busy window
    c0 = cyc;
    e_edge = c0 + 4;
    p_edge = e_edge + 1042 + 9 * 2084;
    fork
      send_frame(0, 8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 4'd0);
      begin
        wait_cyc(e_edge - 1); chk("busy_before_E", 32'(rx_busy[0]), 32'h0);
        wait_cyc(e_edge);     chk("busy_at_E", 32'(rx_busy[0]), 32'h1);
        wait_cyc(p_edge - 1); chk("busy_before_pulse", 32'(rx_busy[0]), 32'h1);
        wait_cyc(p_edge);     chk("busy_at_pulse", 32'(rx_busy[0]), 32'h0);
      end
    join
    repeat (100) @(negedge clk);

    // 500-cycle low glitch on idle line
    c0 = cyc;
    e_edge = c0 + 4;
    rx[0] = 1'b0;
    wait_cyc(e_edge); chk("glitch_busy_at_E", 32'(rx_busy[0]), 32'h1);
    wait_cyc(c0 + 500);
    rx[0] = 1'b1;
    wait_cyc(e_edge + 1042 - 1); chk("glitch_busy_before_check", 32'(rx_busy[0]), 32'h1);
    wait_cyc(e_edge + 1042);     chk("glitch_busy_after_check", 32'(rx_busy[0]), 32'h0);
    repeat (200) @(negedge clk);

    // Back-to-back hex digits at 16 clocks per bit
    send_frame(1, 8'h37, 1'b1, 1'b1, 8'h37, 1'b1, 4'd7);
    send_frame(1, 8'h63, 1'b1, 1'b1, 8'h63, 1'b1, 4'd12);
    send_frame(1, 8'h46, 1'b1, 1'b1, 8'h46, 1'b1, 4'd15);
    repeat (40) @(negedge clk);

    // Good '1', then a break frame, then re-arm with 0x3A
    send_frame(1, 8'h31, 1'b1, 1'b1, 8'h31, 1'b1, 4'd1);
    send_frame(1, 8'hA5, 1'b0, 1'b1, 8'h31, 1'b0, 4'd1);
    repeat (40) @(negedge clk);
    send_frame(1, 8'h3A, 1'b1, 1'b1, 8'h3A, 1'b0, 4'd1);
    repeat (40) @(negedge clk);

    // Reset during data bit 4 of 0xFF, then 0x62
    c0 = cyc;
    fork
      send_frame(1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
      begin
        wait_cyc(c0 + 5 * 16 + 8);
        rstn = 1'b0;
        #1;
        chk_reset_vals(1, "midframe_reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
      end
    join
    repeat (40) @(negedge clk);
    send_frame(1, 8'h62, 1'b1, 1'b1, 8'h62, 1'b1, 4'd11);
    repeat (40) @(negedge clk);

    // Table at the minimum divisor
    for (int v = 0; v < 17; v++) begin
      send_frame(2, vecs[v].b, vecs[v].stop, 1'b1, vecs[v].exp_data,
                 vecs[v].exp_hv, vecs[v].exp_hval);
      if (!vecs[v].stop) repeat (12) @(negedge clk);
    end

    repeat (60) @(negedge clk);
    chk("frames_outstanding", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_hex.md
# uart_rx_hex

Serial receiver for the board's UART link: the receive-side counterpart of the team's 8N1 transmitter. It takes the asynchronous RX pin and recovers 8N1 frames at the same bit period. Each received byte is presented with a one-cycle valid strobe. Bytes that are ASCII hex digits are also decoded to a 4-bit value, the inverse of the transmit-side hex-to-ASCII mapping.

## Interface
Parameters:
- CLKS_PER_BIT, 2084, i_clk cycles per UART bit (2 × 1042; 9600 baud at 20 MHz); legal range 4..4095.
- HALF_BIT, CLKS_PER_BIT/2, start-bit mid-point offset in cycles.

Ports:
- i_clk  input  1  system clock.
- i_rstn  input  1  asynchronous active-low reset.
- i_rx_data  input  1  UART RX pin, idle high, asynchronous to i_clk.
- o_rx_data  output  8  last good received byte; holds until the next good frame.
- o_rx_valid  output  1  one-cycle pulse when o_rx_data updates.
- o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- o_rx_busy  output  1  high while the FSM is outside IDLE.
- o_hex_val  output  4  decoded hex digit of the last good hex byte; holds.
- o_hex_valid  output  1  one-cycle pulse, coincident with o_rx_valid, when the byte is a hex digit.

Reset is i_rstn, asynchronous, active-low; clock is i_clk.

## Operation
- **Synchronizer.** i_rx_data passes through 2 flops plus 1 edge-history flop, all reset to 1.
- **Start detect.** A falling edge (synced 0, history 1) is detected only in IDLE.
- **FSM states.** IDLE, START, DATA, STOP. A 12-bit cycle counter and a 3-bit bit index drive the transitions.
  - IDLE→START on falling edge; counter cleared.
  - START: at counter = HALF_BIT-1, sample the line.
    - Line 1: glitch; return to IDLE with no output pulse.
    - Line 0: go to DATA; counter and index cleared.
  - DATA: at counter = CLKS_PER_BIT-1, sample into shift register bit [index] (LSB first) and clear the counter.
    - After index 7, go to STOP.
  - STOP: at counter = CLKS_PER_BIT-1, sample the line and return to IDLE.
    - Line 1: latch o_rx_data and pulse o_rx_valid.
    - Line 0: pulse o_frame_err; o_rx_data and o_hex_val unchanged.
- **Re-arm after error.** After a low stop bit (break), the next start needs a new falling edge, so the line must return high first.
- **Hex decode.** Combinational from the shift register, registered with o_rx_valid:
  - 0x30–0x39 → 0–9.
  - 0x61–0x66 → 10–15.
  - 0x41–0x46 → 10–15.
  - Any other byte: o_hex_valid stays 0 and o_hex_val holds.
- **Busy.** o_rx_busy = (state != IDLE), registered.
- **Reset mid-frame.** All state and outputs go to reset values immediately; a partial frame is discarded with no pulse.

## Timing
- **Reset values.** o_rx_data=0x00, o_rx_valid=0, o_frame_err=0, o_rx_busy=0, o_hex_val=0, o_hex_valid=0.
- **Edge E.** Let E be the i_clk edge at which the state enters START. E is 3 edges after the first edge that samples i_rx_data low.
- **Sample points.**
  - Start check: edge E+HALF_BIT.
  - Data bit k (k=0..7): edge E+HALF_BIT+(k+1)·CLKS_PER_BIT.
  - Stop bit: edge E+HALF_BIT+9·CLKS_PER_BIT.
- **Result timing.**
  - o_rx_valid, o_frame_err and o_hex_valid assert at the stop-sample edge and are high for exactly 1 cycle.
  - o_rx_data and o_hex_val change on that same edge.
  - o_rx_busy falls on the same edge.
- **Back-to-back frames.** IDLE is re-entered at mid-stop-bit, so a start edge arriving half a bit later is caught. No idle gap is required between frames.
- **Pulse exclusivity.** o_rx_valid and o_frame_err are never high in the same cycle.

## Test plan
- Frame 0x55 at CLKS_PER_BIT=2084, 1 stop bit → o_rx_data=0x55, o_rx_valid pulse width 1 at E+1042+9·2084; o_hex_valid=0; o_rx_busy high from E to the pulse.
- Frames '7' (0x37), 'c' (0x63), 'F' (0x46) back-to-back with no gap → three o_rx_valid pulses; o_hex_val=7, 12, 15, each with an o_hex_valid pulse.
- Low glitch of 500 cycles on idle line → no o_rx_valid or o_frame_err; o_rx_busy returns to 0 at E+1042.
- Frame 0xA5 with stop bit 0 after a good 0x31 → o_frame_err pulse; o_rx_data stays 0x31 and o_hex_val stays 1. After the line goes high, frame 0x3A → o_rx_valid with o_rx_data=0x3A and o_hex_valid=0.
- i_rstn asserted during data bit 4 of frame 0xFF, released, then frame 0x62 sent → no pulse for the aborted frame; all outputs read reset values during reset; next frame gives o_rx_data=0x62, o_hex_val=11.
- CLKS_PER_BIT=4, frame 0x80 → correct byte recovered; verifies sample-point arithmetic at the minimum divisor.
